// File: rtl/tl_pkg.sv
// Shared TileLink-UL/UH opcode constants and the A-channel opcode legality check.
package tl_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  function automatic logic is_legal_a_opcode(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
  endfunction

endpackage

// File: rtl/tl_src_alloc.sv
// Source-ID free list: busy bitmap, lowest-free-index encoder and in-flight count.
module tl_src_alloc #(
  parameter int SRC_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  input  logic                  free_en,
  input  logic [SRC_SIZE-1:0]   free_id,
  output logic                  any_free,
  output logic [SRC_SIZE-1:0]   alloc_id,
  output logic [(1<<SRC_SIZE)-1:0] busy,
  output logic [SRC_SIZE:0]     outstanding
);

  localparam int NSRC = 1 << SRC_SIZE;

  logic [NSRC-1:0]   busy_q;
  logic [SRC_SIZE:0] count_q;

  // Encoder works on the registered bitmap, so a source freed this cycle
  // only becomes a candidate on the following cycle.
  always_comb begin
    alloc_id = '0;
    any_free = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_id = SRC_SIZE'(i);
        any_free = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_en) busy_q[alloc_id] <= 1'b1;
      if (free_en)  busy_q[free_id]  <= 1'b0;
      count_q <= count_q + (SRC_SIZE+1)'(alloc_en) - (SRC_SIZE+1)'(free_en);
    end
  end

  assign busy        = busy_q;
  assign outstanding = count_q;

endmodule

// File: rtl/tl_master_engine.sv
// Single-beat TileLink-UL/UH master: command port to A channel, out-of-order D
// responses to a registered response port, with source tagging and a stall watchdog.
module tl_master_engine
  import tl_pkg::*;
#(
  parameter int SRC_SIZE  = 2,
  parameter int SINK_SIZE = 2,
  parameter int BUS_SIZE  = 8,
  parameter int ADR_WIDTH = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opcode,
  input  logic [3:0]            cmd_size,
  input  logic [ADR_WIDTH-1:0]  cmd_address,
  input  logic [BUS_SIZE-1:0]   cmd_mask,
  input  logic [8*BUS_SIZE-1:0] cmd_data,
  output logic [SRC_SIZE-1:0]   cmd_id,
  output logic                  tl_master_a_valid,
  input  logic                  tl_master_a_ready,
  output logic [2:0]            tl_master_a_opcode,
  output logic [2:0]            tl_master_a_param,
  output logic [3:0]            tl_master_a_size,
  output logic [SRC_SIZE-1:0]   tl_master_a_source,
  output logic [ADR_WIDTH-1:0]  tl_master_a_address,
  output logic [BUS_SIZE-1:0]   tl_master_a_mask,
  output logic [8*BUS_SIZE-1:0] tl_master_a_data,
  output logic                  tl_master_a_corrupt,
  input  logic                  tl_master_d_valid,
  output logic                  tl_master_d_ready,
  input  logic [2:0]            tl_master_d_opcode,
  input  logic [1:0]            tl_master_d_param,
  input  logic [3:0]            tl_master_d_size,
  input  logic [SRC_SIZE-1:0]   tl_master_d_source,
  input  logic [SINK_SIZE-1:0]  tl_master_d_sink,
  input  logic                  tl_master_d_denied,
  input  logic [8*BUS_SIZE-1:0] tl_master_d_data,
  input  logic                  tl_master_d_corrupt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SRC_SIZE-1:0]   rsp_source,
  output logic [2:0]            rsp_opcode,
  output logic [8*BUS_SIZE-1:0] rsp_data,
  output logic                  rsp_denied,
  output logic                  rsp_corrupt,
  output logic [SRC_SIZE:0]     outstanding,
  output logic                  err_illegal_op,
  output logic                  err_unexpected_d,
  output logic                  timeout
);

  localparam int DATA_W = 8 * BUS_SIZE;
  localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid never waits on ready, and a registered payload holds until it transfers.

  logic                       any_free, cmd_fire, cmd_legal, alloc_en;
  logic                       d_fire, d_hit;
  logic [SRC_SIZE-1:0]        alloc_id;
  logic [(1<<SRC_SIZE)-1:0]   busy;
  logic                       a_valid_q, rsp_valid_q, timeout_q;
  logic                       err_illegal_q, err_unexp_q;
  logic [WD_W-1:0]            wd_cnt;
  logic [2:0]                 a_opcode_q, rsp_opcode_q;
  logic [3:0]                 a_size_q;
  logic [SRC_SIZE-1:0]        a_source_q, rsp_source_q;
  logic [ADR_WIDTH-1:0]       a_address_q;
  logic [BUS_SIZE-1:0]        a_mask_q;
  logic [DATA_W-1:0]          a_data_q, rsp_data_q;
  logic                       rsp_denied_q, rsp_corrupt_q;
  logic                       unused_d_fields;

  assign cmd_ready = (!a_valid_q || tl_master_a_ready) && any_free && !timeout_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign cmd_legal = is_legal_a_opcode(cmd_opcode);
  assign alloc_en  = cmd_fire && cmd_legal;
  assign cmd_id    = alloc_id;

  assign tl_master_d_ready = !rsp_valid_q || rsp_ready;
  assign d_fire = tl_master_d_valid && tl_master_d_ready;
  assign d_hit  = d_fire && busy[tl_master_d_source];

  assign unused_d_fields = ^{tl_master_d_param, tl_master_d_size, tl_master_d_sink};

  tl_src_alloc #(.SRC_SIZE(SRC_SIZE)) u_alloc (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_en),
    .free_en     (d_hit),
    .free_id     (tl_master_d_source),
    .any_free    (any_free),
    .alloc_id    (alloc_id),
    .busy        (busy),
    .outstanding (outstanding)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else if (alloc_en) begin
      a_valid_q   <= 1'b1;
      a_opcode_q  <= cmd_opcode;
      a_size_q    <= cmd_size;
      a_source_q  <= alloc_id;
      a_address_q <= cmd_address;
      a_mask_q    <= cmd_mask;
      a_data_q    <= cmd_data;
    end else if (tl_master_a_ready) begin
      a_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_source_q  <= '0;
      rsp_opcode_q  <= '0;
      rsp_data_q    <= '0;
      rsp_denied_q  <= 1'b0;
      rsp_corrupt_q <= 1'b0;
    end else if (d_hit) begin
      rsp_valid_q   <= 1'b1;
      rsp_source_q  <= tl_master_d_source;
      rsp_opcode_q  <= tl_master_d_opcode;
      rsp_data_q    <= tl_master_d_data;
      rsp_denied_q  <= tl_master_d_denied;
      rsp_corrupt_q <= tl_master_d_corrupt;
    end else if (rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  // Watchdog counts cycles with work in flight and no D progress; it freezes
  // once tripped so the sticky flag never re-evaluates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= '0;
      timeout_q     <= 1'b0;
      err_illegal_q <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      if (cmd_fire && !cmd_legal) err_illegal_q <= 1'b1;
      if (d_fire && !d_hit)       err_unexp_q   <= 1'b1;
      if (d_fire || outstanding == '0) begin
        wd_cnt <= '0;
      end else if (!timeout_q) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (TIMEOUT != 0 && wd_cnt == WD_LAST) timeout_q <= 1'b1;
      end
    end
  end

  assign tl_master_a_valid   = a_valid_q;
  assign tl_master_a_opcode  = a_opcode_q;
  assign tl_master_a_param   = 3'd0;
  assign tl_master_a_size    = a_size_q;
  assign tl_master_a_source  = a_source_q;
  assign tl_master_a_address = a_address_q;
  assign tl_master_a_mask    = a_mask_q;
  assign tl_master_a_data    = a_data_q;
  assign tl_master_a_corrupt = 1'b0;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_source  = rsp_source_q;
  assign rsp_opcode  = rsp_opcode_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_denied  = rsp_denied_q;
  assign rsp_corrupt = rsp_corrupt_q;

  assign err_illegal_op   = err_illegal_q;
  assign err_unexpected_d = err_unexp_q;
  assign timeout          = timeout_q;

endmodule

// File: tb/tb_tl_master_engine.sv
// Directed bench for tl_master_engine: drivers push expected A beats and responses
// into queues; negedge monitors pop and compare whenever the DUT presents a transfer.
module tb_tl_master_engine;

  localparam int SRC_SIZE  = 2;
  localparam int SINK_SIZE = 2;
  localparam int BUS_SIZE  = 8;
  localparam int ADR_WIDTH = 32;
  localparam int TIMEOUT   = 16;
  localparam int DATA_W    = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 cmd_valid, cmd_ready;
  logic [2:0]           cmd_opcode;
  logic [3:0]           cmd_size;
  logic [ADR_WIDTH-1:0] cmd_address;
  logic [BUS_SIZE-1:0]  cmd_mask;
  logic [DATA_W-1:0]    cmd_data;
  logic [SRC_SIZE-1:0]  cmd_id;
  logic                 a_valid, a_ready, a_corrupt;
  logic [2:0]           a_opcode, a_param;
  logic [3:0]           a_size;
  logic [SRC_SIZE-1:0]  a_source;
  logic [ADR_WIDTH-1:0] a_address;
  logic [BUS_SIZE-1:0]  a_mask;
  logic [DATA_W-1:0]    a_data;
  logic                 d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]           d_opcode;
  logic [1:0]           d_param;
  logic [3:0]           d_size;
  logic [SRC_SIZE-1:0]  d_source;
  logic [SINK_SIZE-1:0] d_sink;
  logic [DATA_W-1:0]    d_data;
  logic                 rsp_valid, rsp_ready, rsp_denied, rsp_corrupt;
  logic [SRC_SIZE-1:0]  rsp_source;
  logic [2:0]           rsp_opcode;
  logic [DATA_W-1:0]    rsp_data;
  logic [SRC_SIZE:0]    outstanding;
  logic                 err_illegal_op, err_unexpected_d, timeout;

  tl_master_engine #(
    .SRC_SIZE(SRC_SIZE), .SINK_SIZE(SINK_SIZE), .BUS_SIZE(BUS_SIZE),
    .ADR_WIDTH(ADR_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_size(cmd_size), .cmd_address(cmd_address), .cmd_mask(cmd_mask),
    .cmd_data(cmd_data), .cmd_id(cmd_id),
    .tl_master_a_valid(a_valid), .tl_master_a_ready(a_ready),
    .tl_master_a_opcode(a_opcode), .tl_master_a_param(a_param),
    .tl_master_a_size(a_size), .tl_master_a_source(a_source),
    .tl_master_a_address(a_address), .tl_master_a_mask(a_mask),
    .tl_master_a_data(a_data), .tl_master_a_corrupt(a_corrupt),
    .tl_master_d_valid(d_valid), .tl_master_d_ready(d_ready),
    .tl_master_d_opcode(d_opcode), .tl_master_d_param(d_param),
    .tl_master_d_size(d_size), .tl_master_d_source(d_source),
    .tl_master_d_sink(d_sink), .tl_master_d_denied(d_denied),
    .tl_master_d_data(d_data), .tl_master_d_corrupt(d_corrupt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source),
    .rsp_opcode(rsp_opcode), .rsp_data(rsp_data), .rsp_denied(rsp_denied),
    .rsp_corrupt(rsp_corrupt), .outstanding(outstanding),
    .err_illegal_op(err_illegal_op), .err_unexpected_d(err_unexpected_d),
    .timeout(timeout)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [112:0] a_exp_q[$];
  logic [70:0]  exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      if (a_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_beat_unexpected: got source %0d expected no beat", a_source);
      end else begin
        chk("a_beat", {a_opcode, a_size, a_source, a_address, a_mask, a_data}, a_exp_q.pop_front());
        chk("a_param_corrupt", {a_param, a_corrupt}, 4'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got source %0d expected no response", rsp_source);
      end else begin
        chk("rsp", {rsp_source, rsp_opcode, rsp_data, rsp_denied, rsp_corrupt}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [2:0] op, input logic [3:0] sz, input logic [31:0] adr,
                          input logic [7:0] msk, input logic [63:0] dat,
                          input logic [1:0] exp_id, input logic expect_a);
    int n = 0;
    cmd_opcode = op; cmd_size = sz; cmd_address = adr; cmd_mask = msk; cmd_data = dat;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin n++; @(negedge clk); end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_wait: got 0 expected 1 within 20 cycles");
    end else begin
      chk("cmd_id", cmd_id, exp_id);
      if (expect_a) a_exp_q.push_back({op, sz, exp_id, adr, msk, dat});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_d(input logic [1:0] src, input logic [2:0] op, input logic [63:0] dat,
                        input logic den, input logic cor, input logic expect_rsp);
    int n = 0;
    d_source = src; d_opcode = op; d_data = dat; d_denied = den; d_corrupt = cor;
    d_param = 2'd0; d_size = 4'd3; d_sink = 2'd1;
    d_valid = 1'b1;
    @(negedge clk);
    while (!d_ready && n < 20) begin n++; @(negedge clk); end
    if (!d_ready) begin
      checks++; errors++;
      $display("FAIL d_ready_wait: got 0 expected 1 within 20 cycles");
    end else if (expect_rsp) begin
      exp_q.push_back({src, op, dat, den, cor});
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish expected finish before 200us");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    cmd_valid = 0; cmd_opcode = 0; cmd_size = 0; cmd_address = 0; cmd_mask = 0; cmd_data = 0;
    a_ready = 1; rsp_ready = 1;
    d_valid = 0; d_opcode = 0; d_param = 0; d_size = 0; d_source = 0; d_sink = 0;
    d_denied = 0; d_data = 0; d_corrupt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_a_valid", a_valid, 0);
    chk("reset_a_fields", {a_opcode, a_size, a_source, a_address, a_mask, a_data}, 0);
    chk("reset_rsp", {rsp_valid, rsp_source, rsp_opcode, rsp_data, rsp_denied, rsp_corrupt}, 0);
    chk("reset_flags", {outstanding, err_illegal_op, err_unexpected_d, timeout}, 0);
    chk("reset_ready", {d_ready, cmd_ready, cmd_id}, 4'b1100);
    @(posedge clk); #1;

    // single Get
    send_cmd(3'd4, 4'd3, 32'h8000_0000, 8'hff, 64'h0, 2'd0, 1'b1);
    @(negedge clk);
    chk("get_a_latency", {a_valid, a_opcode}, 4'b1100);
    @(posedge clk); #1;
    send_d(2'd0, 3'd1, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("get_outstanding_zero", outstanding, 0);
    @(posedge clk); #1;

    // fill all four sources, then return out of order
    for (int i = 0; i < 4; i++)
      send_cmd(3'd4, 4'd3, 32'h100 + 32'(i) * 8, 8'hff, 64'h0, 2'(i), 1'b1);
    cmd_valid = 1'b1; cmd_opcode = 3'd4;
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_cmd_id", cmd_id, 0);
    chk("full_outstanding", outstanding, 4);
    cmd_valid = 1'b0;
    send_d(2'd2, 3'd1, 64'hA2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("reopen_cmd_ready", {cmd_ready, cmd_id}, 3'b110);
    send_d(2'd0, 3'd1, 64'hA0, 1'b0, 1'b0, 1'b1);
    send_d(2'd3, 3'd1, 64'hA3, 1'b1, 1'b1, 1'b1);
    send_d(2'd1, 3'd1, 64'hA1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ooo_outstanding_zero", outstanding, 0);
    @(posedge clk); #1;

    // same-cycle free of source 1 and allocation
    send_cmd(3'd4, 4'd3, 32'h200, 8'hff, 64'h0, 2'd0, 1'b1);
    send_cmd(3'd4, 4'd3, 32'h208, 8'hff, 64'h0, 2'd1, 1'b1);
    chk("pre_overlap_outstanding", outstanding, 2);
    fork
      send_cmd(3'd0, 4'd3, 32'h210, 8'hff, 64'hCAFE, 2'd2, 1'b1);
      send_d(2'd1, 3'd1, 64'hB1, 1'b0, 1'b0, 1'b1);
    join
    @(negedge clk);
    chk("overlap_outstanding", outstanding, 2);
    chk("overlap_reuse_id", cmd_id, 1);
    send_d(2'd0, 3'd1, 64'hB0, 1'b0, 1'b0, 1'b1);
    send_d(2'd2, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1);

    // A backpressure
    a_ready = 1'b0;
    send_cmd(3'd0, 4'd2, 32'h1000, 8'h0f, 64'hDEAD_BEEF, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_a_fields", {a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data},
          {1'b1, 3'd0, 4'd2, 2'd0, 32'h1000, 8'h0f, 64'hDEAD_BEEF});
      chk("stall_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    a_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_single_beat", a_valid, 0);
    send_d(2'd0, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1);

    // unexpected D and illegal opcode
    send_d(2'd3, 3'd1, 64'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("unexp_flag", {err_unexpected_d, rsp_valid}, 2'b10);
    send_cmd(3'd2, 4'd3, 32'h300, 8'hff, 64'h0, 2'd0, 1'b0);
    @(negedge clk);
    chk("illegal_flag", {err_illegal_op, a_valid, outstanding}, {1'b1, 1'b0, 3'd0});
    @(posedge clk); #1;

    // watchdog
    send_cmd(3'd4, 4'd3, 32'h400, 8'hff, 64'h0, 2'd0, 1'b1);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) chk("timeout_not_yet", timeout, 0);
      if (i == 16) chk("timeout_set", {timeout, cmd_ready}, 2'b10);
    end
    @(posedge clk); #1;
    send_d(2'd0, 3'd1, 64'h4444, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("timeout_sticky", {timeout, outstanding}, {1'b1, 3'd0});
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_reset", {a_valid, rsp_valid, outstanding, err_illegal_op, err_unexpected_d, timeout}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", cmd_ready, 1);
    @(posedge clk); #1;
    send_d(2'd0, 3'd1, 64'h5555, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("late_d_after_reset", {err_unexpected_d, rsp_valid}, 2'b10);

    repeat (2) @(negedge clk);
    chk("a_queue_drained", 128'(a_exp_q.size()), 0);
    chk("rsp_queue_drained", 128'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_master_engine.md
# tl_master_engine

Parametrised, synthesizable TileLink-UL/UH single-beat master engine and successor to the behavioural tile master. It accepts read and write commands on a valid/ready command port, tags each with a free source ID, and keeps up to 2^SRC_SIZE transactions outstanding. D-channel responses return out of order through a registered response port, and a watchdog flags a stalled bus. It replaces a core tile in co-simulation and bus-stress builds.

## Interface
- SRC_SIZE, 2: source ID width; max outstanding = 2^SRC_SIZE
- SINK_SIZE, 2: D sink width
- BUS_SIZE, 8: data bus bytes; DATA_W = 8*BUS_SIZE
- ADR_WIDTH, 32: address width
- TIMEOUT, 1024: watchdog limit in cycles; 0 disables it
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
- cmd_size  in  4  log2 bytes, must be ≤ log2(BUS_SIZE)
- cmd_address  in  ADR_WIDTH  byte address
- cmd_mask  in  BUS_SIZE  byte lanes
- cmd_data  in  DATA_W  write data
- cmd_id  out  SRC_SIZE  source assigned to the command; valid while cmd_ready
- tl_master_a_*  out/in  —  valid, ready, opcode[3], param[3]=0, size[4], source[SRC_SIZE], address[ADR_WIDTH], mask[BUS_SIZE], data[DATA_W], corrupt=0
- tl_master_d_*  in/out  —  valid, ready, opcode[3], param[2], size[4], source[SRC_SIZE], sink[SINK_SIZE], denied, data[DATA_W], corrupt
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_source, rsp_opcode, rsp_data, rsp_denied, rsp_corrupt  out  —  captured D fields
- outstanding  out  SRC_SIZE+1  count of in-flight sources
- err_illegal_op, err_unexpected_d, timeout  out  1  sticky error flags

## Operation
- Free-list bitmap `busy[2^SRC_SIZE]`. The allocator picks the lowest-index clear bit of the current-cycle bitmap.
- cmd_ready = (!a_valid_q || a_ready) && any_free && !timeout.
- On cmd fire with a legal opcode: load the A register and set busy[cmd_id]. a_valid_q stays high until a_ready.
- On cmd fire with an illegal opcode (not 0/1/4): the command is consumed, no A beat is issued, no source is allocated, and err_illegal_op is set.
- tl_master_d_ready = !rsp_valid_q || rsp_ready.
- On D fire with busy[d_source]=1: clear busy[d_source], capture D into the response register, and set rsp_valid.
- On D fire with busy[d_source]=0: set err_unexpected_d, drop the beat, and leave the bitmap unchanged.
- Simultaneous alloc and free: allocation uses the pre-cycle bitmap, so a freed source becomes reusable on the next cycle. outstanding nets +1/−1 in the same cycle.
- Watchdog counter:
  - cleared on any D fire or when outstanding==0.
  - otherwise increments.
  - at TIMEOUT, sets timeout (sticky) and blocks new commands; in-flight responses are still drained.
- Sticky flags clear only on reset.

## Timing
- Reset values: a_valid=0, all A fields 0, rsp_valid=0, rsp fields 0, busy=0, outstanding=0, all error flags 0. d_ready is therefore 1 out of reset.
- Latency:
  - cmd fire → a_valid: 1 cycle (registered).
  - D fire → rsp_valid: 1 cycle.
- Throughput:
  - one command per cycle while a_ready=1 and sources are free.
  - one response per cycle while rsp_ready=1.
- Full (all busy): cmd_ready=0, and cmd_id holds the value 0 but is not meaningful.
- A fields remain stable while a_valid && !a_ready.
- Reset mid-transaction: everything clears asynchronously. Late D beats after reset raise err_unexpected_d.

## Structure
- tl_pkg holds:
  - opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1)
  - the is_legal_a_opcode function
- Sub-module tl_src_alloc: the busy bitmap, the lowest-free priority encoder, alloc/free ports, and the outstanding count.

## Test plan
- Single Get to 0x8000_0000 with size 3, D AccessAckData of data 0x1122334455667788 → cmd_id=0; a_opcode=4 one cycle after cmd fire; rsp_data matches and rsp_source=0; outstanding returns 0.
- Issue 4 commands with SRC_SIZE=2 while D is withheld → sources 0,1,2,3 are assigned; the 5th command sees cmd_ready=0; return responses in order 2,0,3,1 → each rsp_source matches and cmd_ready reasserts after the first.
- Free source 1 via D in the same cycle a command is accepted while source 0 is busy → the command gets source 2, not 1; outstanding is unchanged.
- Hold a_ready=0 for 5 cycles → the A fields stay stable and cmd_ready=0; then raise a_ready → exactly one A beat is accepted.
- D beat with source 3 while busy=0 → err_unexpected_d=1, rsp_valid stays 0; cmd_opcode=2 → err_illegal_op=1 and no A beat is issued.
- With TIMEOUT=16, issue one Get and never respond → timeout=1 after 16 cycles and cmd_ready=0; a late D response is still delivered; asserting reset clears all state.
